multu_hilo_unit: RTL
====================

Name: multu_hilo_unit

Overview:
- Sequential unsigned multiplier with architectural HI/LO registers.
- Sits directly downstream of the single-cycle controller. It consumes the controller's hi_lo_load (multu), select_result (mfhi/mflo read request) and hi_lo (HI/LO select) outputs, plus the rs/rt register-file data.
- Produces the mfhi/mflo result for the writeback mux and a stall that freezes PC/regfile writes while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits and the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  controller hi_lo_load; requests multu of a*b
- a  input  WIDTH  multiplicand (rs data)
- b  input  WIDTH  multiplier (rt data)
- rd_req  input  1  controller select_result; current instruction is mfhi/mflo
- hi_lo  input  1  0 selects HI, 1 selects LO
- rd_data  output  WIDTH  selected HI or LO, combinational
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; HI/LO were just updated
- stall  output  1  rd_req & busy

Behaviour:
- Reset (async, any time, including mid-multiply):
  - state goes to IDLE; hi, lo, busy, done and the internal P/M/Q/count registers go to 0.
  - Any operation in progress is discarded.
- States:
  - IDLE
    - If start=1: load P=0, M={WIDTH'0,a}, Q=b, count=0; go to RUN.
    - Otherwise hold.
  - RUN (busy=1), one step per cycle:
    - If Q[0]: P <= P+M (2*WIDTH-bit add, no overflow possible).
    - M <= M<<1; Q <= Q>>1; count <= count+1.
    - On the step where count==WIDTH-1: write {hi,lo} <= final P (including this step's add) in the same edge; go to DONE.
    - start is ignored while in RUN.
  - DONE (done=1, busy=0)
    - If start=1: begin a new operation exactly as from IDLE.
    - Otherwise go to IDLE.
- Latency:
  - Call the edge that samples start edge 0. Busy is high for WIDTH cycles.
  - hi/lo hold new values after edge WIDTH. done is high during the cycle after edge WIDTH.
- rd_data:
  - Equals hi_lo ? lo : hi, always from the registers, so old values are returned while busy.
- stall:
  - Equals rd_req & busy, purely combinational.
  - An mfhi/mflo in the DONE cycle does not stall and sees the new values.
- HI/LO change only at operation completion; the registers are never partially written.
- Simultaneous start and rd_req in IDLE: no stall; read returns the pre-multiply values.

Optional Feature:
- MULTU_EARLY_TERM_EN
  - Defined: RUN also exits to DONE, with a HI/LO write, on any step where the next Q equals 0. The result is identical; latency becomes max(1, index of highest set bit of b + 1) cycles. b=0 completes after 1 RUN cycle.
  - Undefined: always exactly WIDTH RUN cycles.

Test Plan:
- Basic product: rst pulse, then start with a=7, b=6.
  - busy for 32 cycles, done pulses once.
  - hi=0x00000000, lo=0x0000002A; rd_data=0x2A with hi_lo=1, 0 with hi_lo=0.
- Maximum operands: a=0xFFFFFFFF, b=0xFFFFFFFF.
  - hi=0xFFFFFFFE, lo=0x00000001 after edge 32.
- Start while busy: start a=3, b=5; at cycle 10 assert start with a=100, b=100.
  - The second start is ignored; final hi=0, lo=15; only one done pulse.
- Read stall: mid-multiply assert rd_req=1, hi_lo=0.
  - stall=1 every cycle until busy falls; rd_data shows the old HI during the stall.
  - In the done cycle stall=0 and rd_data shows the new HI.
- Async reset mid-op: start a=0x12345678, b=0x9ABCDEF0; assert rst at cycle 15, asynchronously off the clock edge.
  - busy, hi and lo go to 0 immediately; no done pulse follows; a subsequent 2*2 gives lo=4.
- Early termination, MULTU_EARLY_TERM_EN defined: a=3, b=5.
  - done after 3 RUN cycles, lo=15.
  - b=0 gives done after 1 cycle, hi=lo=0.
  - Without the macro, both cases take 32 cycles.

Source files
------------

// File: rtl/multu_hilo_unit.sv
// Shift-and-add unsigned multiplier feeding architectural HI/LO registers.
// Optional MULTU_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             hi_lo,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     p_q, p_d, m_q, m_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0]     sum_s;
  logic                   last_s;

  // Next-state, datapath step and HI/LO commit.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum_s   = p_q + (q_q[0] ? m_q : {(2*WIDTH){1'b0}});
    last_s  = (cnt_q == CW'(WIDTH - 1));
`ifdef MULTU_EARLY_TERM_EN
    // Once no multiplier bits remain, sum_s already holds the full product.
    last_s  = last_s | ((q_q >> 1) == {WIDTH{1'b0}});
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          p_d     = {(2*WIDTH){1'b0}};
          m_d     = {{WIDTH{1'b0}}, a};
          q_d     = b;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d   = sum_s;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (last_s) begin
          {hi_d, lo_d} = sum_s;
          state_d      = DONE;
        end else begin
          state_d      = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= {(2*WIDTH){1'b0}};
      m_q     <= {(2*WIDTH){1'b0}};
      q_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Reads always see the committed registers, so an in-flight multiply returns old values.
  assign rd_data = hi_lo ? lo_q : hi_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign stall   = rd_req & busy_q;

endmodule
